uart_text_writer: RTL

Downstream consumer of the UART receiver: takes each received byte (8-bit data plus one-cycle valid pulse) and turns it into character-cell writes for the TFT text RAM, maintaining a cursor. Printable ASCII is written at the cursor; CR/LF/BS/FF are interpreted as control codes. A small byte FIFO absorbs bytes that arrive while a multi-cycle screen clear is in progress. The write port feeds the dual-port character RAM read by the TFT scan-out logic.

---
 rtl/uart_display_pkg.sv | 27 ++
 rtl/text_byte_fifo.sv | 53 +++++
 rtl/uart_text_writer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_display_pkg.sv
// uart_display_pkg
// Shared definitions for the UART-to-text-RAM display path:
//   - ASCII control-code constants interpreted by the text writer
//   - bounds of the printable character range
//   - FSM state encoding of the text writer
// Optional feature macro: TEXT_WRITER_CLR_ROW_EN adds the CLEAR_ROW state.
package uart_display_pkg;

  localparam logic [7:0] CHAR_BS       = 8'h08;
  localparam logic [7:0] CHAR_LF       = 8'h0A;
  localparam logic [7:0] CHAR_FF       = 8'h0C;
  localparam logic [7:0] CHAR_CR       = 8'h0D;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;
  localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

`ifdef TEXT_WRITER_CLR_ROW_EN
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_CLEAR_ROW} state_t;
`else
  typedef enum logic [0:0] {ST_CLEAR, ST_IDLE} state_t;
`endif

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHAR_PRINT_LO) && (c <= CHAR_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_byte_fifo.sv
// text_byte_fifo
// Small synchronous FIFO holding received bytes while the text writer is busy.
// A push while full is accepted only if a pop happens in the same cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata     write request and data
//   pop             read request (ignored when empty)
//   rdata           head-of-queue data (valid when !empty)
//   full, empty     status flags
module text_byte_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]       wptr;
  logic [PW:0]       rptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_text_writer.sv
// uart_text_writer
// Converts received UART bytes into character-cell writes for the TFT text RAM
// and tracks the cursor. Printable ASCII is written at the cursor; CR, LF, BS
// and FF are control codes; every other code is dropped. A byte FIFO absorbs
// input while a screen clear is running.
// Ports:
//   system_clock, system_reset   clock, asynchronous active-high reset
//   data_received, received_flag received byte and its one-cycle valid pulse
//   wr_en, wr_addr, wr_data      registered text RAM write port
//   cursor_col, cursor_row       cursor position
//   busy                         screen (or row) clear in progress
//   overflow                     sticky: a byte was dropped on a full FIFO
// Optional feature macro: TEXT_WRITER_CLR_ROW_EN -- every row advance blanks
// the new row before further bytes are processed.
module uart_text_writer
  import uart_display_pkg::*;
#(
  parameter  int COLS       = 40,
  parameter  int ROWS       = 15,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_W     = $clog2(COLS * ROWS),
  localparam int CW         = $clog2(COLS),
  localparam int RW         = $clog2(ROWS)
) (
  input  logic              system_clock,
  input  logic              system_reset,
  input  logic [7:0]        data_received,
  input  logic              received_flag,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [CW-1:0]     cursor_col,
  output logic [RW-1:0]     cursor_row,
  output logic              busy,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [7:0]        byte_p0;
  logic              vld_p0;
  logic              fifo_full;
  logic              fifo_empty;
  logic [RW-1:0]     row_next;
  logic [CW-1:0]     col_prev;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [RW-1:0] r,
                                                  input logic [CW-1:0] c);
    return ADDR_W'(int'(r) * COLS + int'(c));
  endfunction

  // Pops are held off for the one cycle after a clear while busy drops, so the
  // first queued byte lands one cycle after busy falls.
  assign vld_p0   = (state == ST_IDLE) && !busy && !fifo_empty;
  assign row_next = (cursor_row == ROW_LAST) ? '0 : cursor_row + RW'(1);
  assign col_prev = cursor_col - CW'(1);

  text_byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (system_clock),
    .rst   (system_reset),
    .push  (received_flag),
    .wdata (data_received),
    .pop   (vld_p0),
    .rdata (byte_p0),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) overflow <= 1'b0;
    else if (received_flag && fifo_full && !vld_p0) overflow <= 1'b1;
  end

  // Stage p0 (FIFO head decode) -> registered write port and cursor
  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      busy       <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= clr_cnt;
          wr_data <= CHAR_SPACE;
          if (clr_cnt == CELL_LAST) begin
            // busy stays high through the last write; IDLE lowers it.
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end

        ST_IDLE: begin
          busy <= 1'b0;
          if (vld_p0) begin
            if (is_printable(byte_p0)) begin
              wr_en   <= 1'b1;
              wr_addr <= cell_addr(cursor_row, cursor_col);
              wr_data <= byte_p0;
              if (cursor_col == COL_LAST) begin
                cursor_col <= '0;
                cursor_row <= row_next;
`ifdef TEXT_WRITER_CLR_ROW_EN
                state   <= ST_CLEAR_ROW;
                busy    <= 1'b1;
                clr_cnt <= '0;
`endif
              end else begin
                cursor_col <= cursor_col + CW'(1);
              end
            end else begin
              case (byte_p0)
                CHAR_CR: cursor_col <= '0;
                CHAR_LF: begin
                  cursor_col <= '0;
                  cursor_row <= row_next;
`ifdef TEXT_WRITER_CLR_ROW_EN
                  // The first cell of the new row is blanked right away so
                  // busy covers exactly the COLS row-clear writes.
                  wr_en   <= 1'b1;
                  wr_addr <= cell_addr(row_next, '0);
                  wr_data <= CHAR_SPACE;
                  state   <= ST_CLEAR_ROW;
                  busy    <= 1'b1;
                  clr_cnt <= ADDR_W'(1);
`endif
                end
                CHAR_BS: begin
                  if (cursor_col != '0) begin
                    cursor_col <= col_prev;
                    wr_en      <= 1'b1;
                    wr_addr    <= cell_addr(cursor_row, col_prev);
                    wr_data    <= CHAR_SPACE;
                  end
                end
                CHAR_FF: begin
                  state   <= ST_CLEAR;
                  busy    <= 1'b1;
                  clr_cnt <= '0;
                end
                default: ;
              endcase
            end
          end
        end

`ifdef TEXT_WRITER_CLR_ROW_EN
        ST_CLEAR_ROW: begin
          wr_en   <= 1'b1;
          wr_addr <= cell_addr(cursor_row, clr_cnt[CW-1:0]);
          wr_data <= CHAR_SPACE;
          if (clr_cnt[CW-1:0] == COL_LAST) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
`endif

        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule
